// File: rtl/toeplitz_hash.sv
// Bit-serial Toeplitz hasher: one matrix column per clock, GF(2) product
// of an N-bit block with the LxN Toeplitz matrix T.
//
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   rrow0[N]     T[0][k+1] at bit k (bit N-1 unused), static per block
//   col0[L]      T[i][0] at bit L-1-i, static per block
//   in_data[BS]  input word, MSB is the earliest bit
//   in_valid     input word valid
//   in_ready     hasher can take a word (LOAD state)
//   hash[L]      row i of T*x at bit L-1-i
//   hash_valid   hash valid (DONE state)
//   hash_ready   downstream takes hash
module toeplitz_hash #(
   parameter int BS = 64,
   parameter int N  = 256,
   parameter int L  = 128
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [N-1:0]  rrow0,
   input  logic [L-1:0]  col0,
   input  logic [BS-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [L-1:0]  hash,
   output logic          hash_valid,
   input  logic          hash_ready
);

   localparam int BW = (BS > 1) ? $clog2(BS) : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [L-1:0]  r_colreg;
   logic [L-1:0]  r_acc;
   logic [BS-1:0] r_wbuf;
   logic [BW-1:0] r_bitcnt;
   logic [CW-1:0] r_colcnt;

   logic          w_in_ready;
   logic          w_hash_valid;
   logic          w_accept;
   logic          w_shift;
   logic          w_word_end;
   logic          w_col_last;
   logic          w_x;
   logic [L-1:0]  w_term;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and handshake outputs, decoded from registered state only
   always_comb begin
      w_state_nxt  = r_state;
      w_in_ready   = 1'b0;
      w_hash_valid = 1'b0;
      unique case (r_state)
         S_LOAD: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_word_end) begin
               w_state_nxt = w_col_last ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            w_hash_valid = 1'b1;
            if (hash_ready) begin
               w_state_nxt = S_LOAD;
            end
         end
         default: begin
            w_state_nxt = S_LOAD;
         end
      endcase
   end

   assign in_ready   = w_in_ready;
   assign hash_valid = w_hash_valid;
   assign hash       = r_acc;

   assign w_accept   = w_in_ready & in_valid;
   assign w_shift    = (r_state == S_SHIFT);
   assign w_word_end = (r_bitcnt == BW'(BS - 1));
   assign w_col_last = (r_colcnt == CW'(N - 1));

   // Current input bit: word MSB first
   assign w_x    = r_wbuf[BW'(BS - 1) - r_bitcnt];
   assign w_term = {L{w_x}} & r_colreg;

   // Datapath
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_colreg <= '0;
         r_acc    <= '0;
         r_wbuf   <= '0;
         r_bitcnt <= '0;
         r_colcnt <= '0;
      end else begin
         if (w_accept) begin
            r_wbuf <= in_data;
            // First word of a block restarts the column walk
            if (r_colcnt == '0) begin
               r_colreg <= col0;
               r_acc    <= '0;
            end
         end
         if (w_shift) begin
            r_acc <= r_acc ^ w_term;
            // Moving one column right pushes every row down by one;
            // row 0 of the next column comes from rrow0.
            r_colreg <= {rrow0[r_colcnt], r_colreg[L-1:1]};
            r_bitcnt <= w_word_end ? '0 : r_bitcnt + BW'(1);
            r_colcnt <= w_col_last ? '0 : r_colcnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_toeplitz_hash.sv
// Bench for toeplitz_hash: directed small-matrix cases plus random
// full-size blocks against a plain matrix-product reference.
module tb_toeplitz_hash;

   localparam int BS = 64;
   localparam int N  = 256;
   localparam int L  = 128;
   localparam int W  = N / BS;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // full-size instance
   logic [N-1:0]  rrow0;
   logic [L-1:0]  col0;
   logic [BS-1:0] in_data  = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [L-1:0]  hash;
   logic          hash_valid;
   logic          hash_ready = 1'b0;

   // small instance
   logic [7:0] s_rrow0;
   logic [3:0] s_col0;
   logic [3:0] s_in_data  = '0;
   logic       s_in_valid = 1'b0;
   logic       s_in_ready;
   logic [3:0] s_hash;
   logic       s_hash_valid;
   logic       s_hash_ready = 1'b0;

   logic [BS-1:0] blk [W];

   toeplitz_hash #(.BS(BS), .N(N), .L(L)) u_big (
      .clk        (clk),
      .rstn       (rstn),
      .rrow0      (rrow0),
      .col0       (col0),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .hash       (hash),
      .hash_valid (hash_valid),
      .hash_ready (hash_ready)
   );

   toeplitz_hash #(.BS(4), .N(8), .L(4)) u_small (
      .clk        (clk),
      .rstn       (rstn),
      .rrow0      (s_rrow0),
      .col0       (s_col0),
      .in_data    (s_in_data),
      .in_valid   (s_in_valid),
      .in_ready   (s_in_ready),
      .hash       (s_hash),
      .hash_valid (s_hash_valid),
      .hash_ready (s_hash_ready)
   );

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tmo(string tag);
      total++;
      bad++;
      $error("FAIL %s timeout observed=waiting expected=event", tag);
   endtask

   // T*x from the Toeplitz definition: T[i][j] depends only on j-i
   function automatic logic [127:0] model(int l, int n, logic [255:0] rr,
                                          logic [127:0] c0, logic [255:0] x);
      logic [127:0] h;
      logic t;
      logic p;
      h = '0;
      for (int i = 0; i < l; i++) begin
         p = 1'b0;
         for (int j = 0; j < n; j++) begin
            if (j == i)     t = c0[l-1];
            else if (j > i) t = rr[j-i-1];
            else            t = c0[l-1-(i-j)];
            p = p ^ (t & x[j]);
         end
         h[l-1-i] = p;
      end
      return h;
   endfunction

   function automatic logic [255:0] blk_x();
      logic [255:0] x;
      x = '0;
      for (int w = 0; w < W; w++)
         for (int b = 0; b < BS; b++)
            x[BS*w+b] = blk[w][BS-1-b];
      return x;
   endfunction

   function automatic logic [127:0] big_exp();
      return model(L, N, rrow0, col0, blk_x());
   endfunction

   task automatic rand_mat();
      for (int k = 0; k < N / 32; k++) rrow0[32*k +: 32] = $urandom();
      for (int k = 0; k < L / 32; k++) col0[32*k +: 32] = $urandom();
   endtask

   task automatic rand_blk();
      for (int w = 0; w < W; w++) blk[w] = {$urandom(), $urandom()};
   endtask

   task automatic s_run(logic [3:0] w0, logic [3:0] w1,
                        logic [3:0] exp, string tag);
      logic [3:0] wd [2];
      int n;
      wd[0] = w0;
      wd[1] = w1;
      for (int k = 0; k < 2; k++) begin
         s_in_valid = 1'b1;
         s_in_data  = wd[k];
         n = 0;
         while (!s_in_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!s_in_ready) tmo({tag, "_acc"});
         @(negedge clk);
      end
      s_in_valid = 1'b0;
      n = 0;
      while (!s_hash_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_hash_valid) tmo({tag, "_hv"});
      chk(tag, s_hash, exp);
      s_hash_ready = 1'b1;
      @(negedge clk);
      s_hash_ready = 1'b0;
      chk({tag, "_rdy"}, s_in_ready, 1'b1);
   endtask

   // Send nw words of blk; gaps only stretch LOAD
   task automatic b_send(int nw, int maxgap, output int t0);
      int n;
      int gap;
      t0 = 0;
      for (int k = 0; k < nw; k++) begin
         n = 0;
         while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
         end
         if (!in_ready) tmo("b_acc");
         gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
         if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = blk[k];
         @(negedge clk);
         if (k == 0) t0 = cyc;
      end
      in_valid = 1'b0;
   endtask

   task automatic b_get(int hold, logic [127:0] exp, string tag,
                        output int tv);
      int n;
      n = 0;
      while (!hash_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!hash_valid) tmo({tag, "_hv"});
      tv = cyc;
      chk(tag, hash, exp);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk({tag, "_hold"}, {hash_valid, hash}, {1'b1, exp});
         chk({tag, "_hold_rdy"}, in_ready, 1'b0);
      end
      hash_ready = 1'b1;
      @(negedge clk);
      hash_ready = 1'b0;
      chk({tag, "_rdy"}, {in_ready, hash_valid}, 2'b10);
   endtask

   int t0;
   int tv;

   initial begin
      rand_mat();
      s_col0  = 4'b1000;
      s_rrow0 = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_big", {in_ready, hash_valid, hash}, {1'b1, 1'b0, 128'h0});
      chk("rst_small", {s_in_ready, s_hash_valid, s_hash}, 6'b100000);
      rstn = 1'b1;
      @(negedge clk);

      // diagonal matrix
      s_run(4'b1000, 4'b0000, 4'b1000, "diag_x0");
      s_run(4'b0100, 4'b0000, 4'b0100, "diag_x1");
      s_run(4'b0000, 4'b0001, 4'b0000, "diag_x7");

      // all-ones matrix: every row is the parity of x
      s_col0  = 4'hF;
      s_rrow0 = 8'hFF;
      s_run(4'hF, 4'h1, 4'hF, "ones_odd");
      s_run(4'h3, 4'h0, 4'h0, "ones_even");

      // first full block, latency from first accept to hash_valid
      rand_blk();
      b_send(W, 0, t0);
      b_get(0, big_exp(), "lat_blk", tv);
      chk("latency", 128'(tv - t0), 128'(259));

      // backpressure
      rand_blk();
      b_send(W, 0, t0);
      b_get(10, big_exp(), "bp_blk", tv);
      rand_blk();
      b_send(W, 0, t0);
      b_get(0, big_exp(), "after_bp", tv);

      // random blocks
      for (int b = 0; b < 100; b++) begin
         if (b % 25 == 0) rand_mat();
         rand_blk();
         b_send(W, 0, t0);
         b_get(0, big_exp(), "rnd", tv);
         chk("rnd_lat", 128'(tv - t0), 128'(259));
      end

      // reset mid-block after 2 of 4 words
      rand_blk();
      b_send(2, 0, t0);
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("midrst", {in_ready, hash_valid, hash}, {1'b1, 1'b0, 128'h0});
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      rand_blk();
      b_send(W, 0, t0);
      b_get(0, big_exp(), "post_rst", tv);

      // random gaps between words
      for (int b = 0; b < 6; b++) begin
         rand_blk();
         b_send(W, 0, t0);
         b_get(0, big_exp(), "nogap", tv);
         b_send(W, 5, t0);
         b_get(0, big_exp(), "gap", tv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "global timeout");
   end

endmodule
